// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue.
//   master : fetch + decode side (drives flush, in_*, out_ready; observes the rest)
//   slave  : the queue itself
// Signals:
//   flush      redirect, empties the queue
//   in_valid / in_ready / in_pc / in_instr      fetch -> queue
//   out_valid / out_ready / out_pc / out_instr  queue -> decode
//   count      occupied entries, 0..DEPTH
interface fetch_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CNT_W-1:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode.
// Fetch may run ahead while decode stalls; flush empties the queue in one cycle.
// An empty queue presents a zeroed bubble on out_pc/out_instr.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-high reset (priority over flush)
//   bus    fetch_queue_if.slave: flush, in_* handshake, out_* handshake, count
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    memPc    [DEPTH];
    logic [INSTR_W-1:0] memInstr [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [CNT_W-1:0]   count;

    logic inReady;
    logic outValid;
    logic push;
    logic pop;

    // Ready depends on registered occupancy only, so a full queue refuses a
    // push even when decode pops in the same cycle.
    assign inReady  = (count != CNT_W'(DEPTH));
    assign outValid = (count != '0);
    assign push     = bus.in_valid & inReady & ~bus.flush;
    assign pop      = outValid & bus.out_ready & ~bus.flush;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            memPc[wrPtr]    <= bus.in_pc;
            memInstr[wrPtr] <= bus.in_instr;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_pc    = outValid ? memPc[rdPtr]    : '0;
    assign bus.out_instr = outValid ? memInstr[rdPtr] : '0;
    assign bus.count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int     nVec  = 0;
    int     nFail = 0;
    entry_t expQ[$];
    logic   monOn = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard each negedge, then
    // advances the scoreboard with the inputs that the next posedge will see.
    initial begin
        wait (monOn);
        forever begin
            @(negedge clk);
            chk("mon_count",    64'(bus.count),     64'(expQ.size()));
            chk("mon_in_ready", 64'(bus.in_ready),  64'(expQ.size() != DEPTH));
            chk("mon_out_valid",64'(bus.out_valid), 64'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                chk("mon_out_pc",    bus.out_pc,           expQ[0].pc);
                chk("mon_out_instr", 64'(bus.out_instr),   64'(expQ[0].instr));
            end else begin
                chk("mon_bubble_pc",    bus.out_pc,         64'h0);
                chk("mon_bubble_instr", 64'(bus.out_instr), 64'h0);
            end
            if (reset || bus.flush) begin
                expQ.delete();
            end else begin
                logic doPush;
                doPush = bus.in_valid && (expQ.size() != DEPTH);
                if ((expQ.size() != 0) && bus.out_ready) void'(expQ.pop_front());
                if (doPush) expQ.push_back('{pc: bus.in_pc, instr: bus.in_instr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        monOn = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pushN(input int n, input logic [63:0] basePc);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_pc    = basePc + 64'(4 * i);
            bus.in_instr = 32'h0000_0013 + 32'(i << 7);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        // 1 reset
        doReset();
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc",    bus.out_pc,         64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

        // 2 fill
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = 64'h8000_0000 + 64'(4 * i);
            tick();
        end
        chk("fill_count",    64'(bus.count),    64'd4);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_head_pc",  bus.out_pc,        64'h8000_0000);
        bus.in_pc = 64'h8000_0010;
        tick();
        chk("fill_5th_count",   64'(bus.count), 64'd4);
        chk("fill_5th_head_pc", bus.out_pc,     64'h8000_0000);
        bus.in_valid = 1'b0;

        // 3 drain in order
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    bus.out_pc,         64'h8000_0000 + 64'(4 * i));
            chk("drain_instr", 64'(bus.out_instr), 64'h13);
            tick();
        end
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_count",     64'(bus.count),     64'd0);

        // 4 simultaneous push/pop at count=2
        pushN(2, 64'h100);
        chk("sim_pre_count", 64'(bus.count), 64'd2);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_pc    = 64'h108 + 64'(4 * k);
            bus.in_instr = 32'hA000_0000 + 32'(k);
            chk("sim_out_pc", bus.out_pc, 64'h100 + 64'(4 * k));
            tick();
            chk("sim_count", 64'(bus.count), 64'd2);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("sim_drained", 64'(bus.count), 64'd0);

        // 5 wrap with random stalls
        begin
            int sent = 0;
            int cyc  = 0;
            while (!(sent == 3 * DEPTH && expQ.size() == 0) && cyc < 500) begin
                bus.in_valid  = (sent < 3 * DEPTH);
                bus.in_pc     = 64'h4000 + 64'(4 * sent);
                bus.in_instr  = 32'hC0DE_0000 + 32'(sent);
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.in_valid && expQ.size() != DEPTH) sent++;
                tick();
                cyc++;
            end
            chk("wrap_timeout", 64'(cyc < 500), 64'd1);
            bus.in_valid = 1'b0;
            chk("wrap_count", 64'(bus.count), 64'd0);
        end

        // 6 flush with a live in beat
        pushN(3, 64'h2000);
        chk("flush_pre_count", 64'(bus.count), 64'd3);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 64'hDEAD;
        bus.out_ready = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_count",     64'(bus.count),     64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("flush_beat_dropped", 64'(bus.count), 64'd0);

        // 6b reset in place of flush
        pushN(3, 64'h3000);
        chk("reset_pre_count", 64'(bus.count), 64'd3);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 64'hBEEF;
        bus.out_ready = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("reset_count",     64'(bus.count),     64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("reset_beat_dropped", 64'(bus.count), 64'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
